// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: drives the fabric configuration scan chain from a
// word-wide bitstream source. Words arrive on a valid/ready handshake and are
// shifted out LSB-first on ccff_head, with chain_clk_en gating prog_clk so the
// chain only advances on cycles that carry a real bit.
// Optional feature: define CCFF_CHAIN_VERIFY_EN to prepend SENTINEL and check
// it on ccff_tail once it has travelled the full chain length.
module ccff_chain_loader #(
  parameter int                WORD_W    = 32,
  parameter int                CHAIN_LEN = 1024,
  parameter int                SENT_W    = 16,
  parameter logic [SENT_W-1:0] SENTINEL  = 16'hC3A5
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              chain_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // Number of bitstream words and the index of the last bit that is actually
  // shifted out of the final (possibly partial) word.
  localparam int NWORDS   = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_IDX = (CHAIN_LEN - 1) % WORD_W;
  localparam int IDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int WCNT_W   = $clog2(NWORDS + 1);

  localparam logic [IDX_W-1:0]  FULL_LAST = IDX_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0]  PART_LAST = IDX_W'(LAST_IDX);
  localparam logic [WCNT_W-1:0] WORDS_ALL = WCNT_W'(NWORDS);

`ifdef CCFF_CHAIN_VERIFY_EN
  localparam int SIDX_W  = (SENT_W > 1) ? $clog2(SENT_W) : 1;
  localparam int SHIFT_W = $clog2(CHAIN_LEN + SENT_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SENT = 2'd1,
    LOAD = 2'd2,
    DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd2,
    DONE = 2'd3
  } state_t;
`endif

  state_t state_reg, state_next;

  // Single word buffer: the word currently being serialized.
  logic [WORD_W-1:0] buf_reg, buf_next;
  logic              buf_valid_reg, buf_valid_next;
  logic              buf_last_reg, buf_last_next;   // buffered word is the final one
  logic [IDX_W-1:0]  bit_idx_reg, bit_idx_next;
  logic [WCNT_W-1:0] words_left_reg, words_left_next;

  logic [IDX_W-1:0]  last_bit;
  logic              at_last;

`ifdef CCFF_CHAIN_VERIFY_EN
  logic [SIDX_W-1:0]  sent_idx_reg, sent_idx_next;
  logic [SHIFT_W-1:0] shift_cnt_reg, shift_cnt_next;   // enabled cycles since start
  logic               error_reg, error_next;
  logic               sent_win;
  logic [SHIFT_W-1:0] sent_off;
`else
  // Without verification the tail and the sentinel have no consumer.
  logic              unused_tail;
  logic [SENT_W-1:0] unused_sentinel;
  assign unused_tail     = ccff_tail;
  assign unused_sentinel = SENTINEL;
`endif

  // The final word only shifts its low bits; upper bits are dropped.
  assign last_bit = buf_last_reg ? PART_LAST : FULL_LAST;
  assign at_last  = (bit_idx_reg == last_bit);

  // Next-state logic and flop-derived outputs (no input-to-output paths).
  always_comb begin
    state_next      = state_reg;
    buf_next        = buf_reg;
    buf_valid_next  = buf_valid_reg;
    buf_last_next   = buf_last_reg;
    bit_idx_next    = bit_idx_reg;
    words_left_next = words_left_reg;
    word_ready      = 1'b0;
    ccff_head       = 1'b0;
    chain_clk_en    = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
`ifdef CCFF_CHAIN_VERIFY_EN
    sent_idx_next   = sent_idx_reg;
    shift_cnt_next  = shift_cnt_reg;
    error_next      = error_reg;
    sent_win        = 1'b0;
    sent_off        = '0;
`endif

    case (state_reg)
      IDLE: begin
        if (start) begin
          buf_next        = '0;
          buf_valid_next  = 1'b0;
          buf_last_next   = 1'b0;
          bit_idx_next    = '0;
          words_left_next = WORDS_ALL;
`ifdef CCFF_CHAIN_VERIFY_EN
          sent_idx_next   = '0;
          shift_cnt_next  = '0;
          error_next      = 1'b0;
          state_next      = SENT;
`else
          state_next      = LOAD;
`endif
        end
      end

`ifdef CCFF_CHAIN_VERIFY_EN
      SENT: begin
        busy          = 1'b1;
        chain_clk_en  = 1'b1;
        ccff_head     = SENTINEL[sent_idx_reg];
        sent_idx_next = sent_idx_reg + 1'b1;
        if (sent_idx_reg == SIDX_W'(SENT_W - 1)) begin
          state_next = LOAD;
        end
      end
`endif

      LOAD: begin
        busy         = 1'b1;
        chain_clk_en = buf_valid_reg;
        ccff_head    = buf_reg[bit_idx_reg];
        // Refill is allowed in the same cycle the last bit leaves the buffer,
        // so a continuously valid source never sees a bubble.
        word_ready   = (words_left_reg != '0) && (!buf_valid_reg || at_last);

        if (buf_valid_reg) begin
          bit_idx_next = bit_idx_reg + 1'b1;
          if (at_last) begin
            buf_valid_next = 1'b0;
            if (buf_last_reg) begin
              state_next = DONE;
            end
          end
        end

        if (word_valid && word_ready) begin
          buf_next        = word_data;
          buf_valid_next  = 1'b1;
          bit_idx_next    = '0;
          buf_last_next   = (words_left_reg == WCNT_W'(1));
          words_left_next = words_left_reg - 1'b1;
        end
      end

      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

`ifdef CCFF_CHAIN_VERIFY_EN
    // The sentinel emerges on the tail once c reaches CHAIN_LEN.
    if (chain_clk_en) begin
      shift_cnt_next = shift_cnt_reg + 1'b1;
      sent_win = (shift_cnt_reg >= SHIFT_W'(CHAIN_LEN)) &&
                 (shift_cnt_reg <  SHIFT_W'(CHAIN_LEN + SENT_W));
      sent_off = shift_cnt_reg - SHIFT_W'(CHAIN_LEN);
      if (sent_win && (ccff_tail != SENTINEL[sent_off[SIDX_W-1:0]])) begin
        error_next = 1'b1;
      end
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Buffer, index and word-count registers.
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      buf_reg        <= '0;
      buf_valid_reg  <= 1'b0;
      buf_last_reg   <= 1'b0;
      bit_idx_reg    <= '0;
      words_left_reg <= '0;
    end else begin
      buf_reg        <= buf_next;
      buf_valid_reg  <= buf_valid_next;
      buf_last_reg   <= buf_last_next;
      bit_idx_reg    <= bit_idx_next;
      words_left_reg <= words_left_next;
    end
  end

`ifdef CCFF_CHAIN_VERIFY_EN
  // Sentinel index, shift counter and sticky mismatch flag.
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      sent_idx_reg  <= '0;
      shift_cnt_reg <= '0;
      error_reg     <= 1'b0;
    end else begin
      sent_idx_reg  <= sent_idx_next;
      shift_cnt_reg <= shift_cnt_next;
      error_reg     <= error_next;
    end
  end

  assign error = error_reg;
`else
  assign error = 1'b0;
`endif

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Configuration-chain driver that feeds the fabric's `ccff_head` → `ccff_tail` scan chain from a word-wide bitstream source. Accepts bitstream words over a valid/ready handshake, serializes them LSB-first onto `ccff_head`, and emits `chain_clk_en` for the external clock gate on `prog_clk`, so the chain advances only on cycles that carry a valid bit. With verification compiled in, it prepends a sentinel and checks it on `ccff_tail`, confirming chain length and continuity.

## Interface
Parameters:
- `WORD_W`, 32: bitstream word width.
- `CHAIN_LEN`, 1024: total flops in the configuration chain; minimum 1.
- `SENT_W`, 16: sentinel length; used only with verify.
- `SENTINEL`, 16'hC3A5: sentinel pattern, shifted bit 0 first.

Ports:
- `prog_clk`  in  1  configuration clock. One clock domain; reset is synchronous and active-low.
- `prog_reset_n`  in  1  synchronous active-low reset.
- `start`  in  1  single-cycle load request.
- `word_data`  in  WORD_W  bitstream word; bit 0 is shifted first.
- `word_valid`  in  1  `word_data` is valid.
- `word_ready`  out  1  the word is accepted on a cycle where `word_valid && word_ready`.
- `ccff_head`  out  1  serial data into the chain.
- `chain_clk_en`  out  1  the chain shifts at the end of every cycle where this is 1.
- `ccff_tail`  in  1  chain output; sampled only on enabled cycles.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse when the last bit has been shifted.
- `error`  out  1  sticky sentinel mismatch; tied 0 without verify.

## Operation
- States:
  - IDLE.
  - SENT: present only with verify.
  - LOAD.
  - DONE.
- IDLE:
  - `start` → SENT when verify is compiled in, otherwise → LOAD.
  - On this transition, clear the counters, the buffer and `error`.
  - `start` in any other state is ignored.
- SENT:
  - `chain_clk_en` = 1 every cycle.
  - `ccff_head` = `SENTINEL[sent_idx]`.
  - After `SENT_W` enabled cycles → LOAD.
- LOAD:
  - Buffering: a single word buffer with a bit index.
  - `ccff_head` = `buf[bit_idx]`.
  - `chain_clk_en` = `buf_valid`.
  - `word_ready` = words_remaining > 0 && (!`buf_valid` || (bit_idx == last_bit && `chain_clk_en`)). This allows a same-cycle refill, so a continuously valid source sees zero bubbles.
  - Word count: words = ceil(`CHAIN_LEN`/`WORD_W`).
  - Partial last word: only bits [(`CHAIN_LEN`−1) mod `WORD_W` : 0] are shifted; the upper bits are discarded.
  - Source starvation: `chain_clk_en` = 0 and the chain holds; no bit is lost or duplicated.
  - After the `CHAIN_LEN`th data bit has been shifted → DONE.
- DONE: `done` = 1 for one cycle → IDLE.
- `busy` = 1 in SENT, LOAD and DONE.
- Shift index:
  - c counts enabled cycles since `start`.
  - Total shifts = `CHAIN_LEN` + (`SENT_W` with verify, else 0).
  - In the enabled cycle with index c, `ccff_tail` carries the bit shifted at index c − `CHAIN_LEN`, for c ≥ `CHAIN_LEN`.
- Reset (`prog_reset_n` = 0 on an edge) returns the block to IDLE with:
  - `word_ready`, `chain_clk_en`, `ccff_head`, `busy`, `done` and `error` all 0.
  - Counters and the buffer cleared.
- Reset mid-load aborts the load: partial chain contents are left as-is and the host must restart.

## Timing
- `word_ready`, `ccff_head` and `chain_clk_en` are derived from flops only. There is no combinational path from `word_valid`, `word_data` or `ccff_tail` to any output.
- `start` → first enabled cycle (`chain_clk_en` = 1): next cycle in SENT. In LOAD, one cycle after the first word is accepted.
- Load duration with an uninterrupted source: `busy` high for 1 + total shifts + 1 cycles.
- `done` is asserted the cycle after the final enabled cycle.
- `ccff_tail` is sampled at the same edge the chain shifts on.
- Simultaneous `start` and `prog_reset_n` = 0: reset wins.

## Configuration
- `CCFF_CHAIN_VERIFY_EN` defined:
  - SENT state present; `SENTINEL` is shifted before the data.
  - In enabled cycles c ∈ [`CHAIN_LEN`, `CHAIN_LEN`+`SENT_W`−1], compare `ccff_tail` against `SENTINEL[c−CHAIN_LEN]`.
  - Any mismatch sets `error` = 1, which holds until the next accepted `start` or reset. `done` still pulses.
  - Final chain contents are the data bits only.
- `CCFF_CHAIN_VERIFY_EN` undefined:
  - No SENT state; total shifts = `CHAIN_LEN`.
  - `error` is constant 0.

## Test plan
- Basic load (`CHAIN_LEN`=40, `WORD_W`=32, verify off):
  - Stimulus: `start`, then words 0xA5A5A5A5 and 0x0000003C with `word_valid` held high.
  - Required: exactly 40 enabled cycles, the `ccff_head` sequence equals bits 0..39 LSB-first, the chain model holds the expected bits, and `done` is high for 1 cycle.
- Source stalls:
  - Stimulus: drop `word_valid` for 5 cycles between the two words.
  - Required: `chain_clk_en` = 0 for those cycles, and the final chain contents are identical to the basic load.
- Verify pass:
  - Setup: `CCFF_CHAIN_VERIFY_EN` defined, 40-flop chain model.
  - Required: 56 enabled cycles; SENT_W = 16 leading bits equal 0xC3A5 LSB-first; `error` = 0; chain holds the 40 data bits.
- Verify fail:
  - Setup: chain model of length 39.
  - Required: `error` = 1 by `done` and stays 1 until the next `start`.
- Reset mid-load:
  - Stimulus: assert `prog_reset_n` = 0 after 20 enabled cycles.
  - Required: on the next edge all outputs are 0; a new `start` performs a full load from bit 0.
- Start while busy:
  - Stimulus: pulse `start` mid-LOAD.
  - Required: no effect — same cycle count and a single `done`.
